ycbcr2rgb: RTL

//  Converts a full-range (JPEG/BT.601) YCbCr 4:4:4 pixel stream back to 8-bit RGB.
//  It is the inverse of the forward RGB->YCbCr stage and feeds video output and debug overlay paths.

---
 rtl/ycbcr2rgb.sv | 103 ++++++++++
 1 files changed

// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr 4:4:4 to 8-bit RGB converter.
// Four-stage, clock-enabled pipeline with the de/hsync/vsync path delayed to match.
module ycbcr2rgb #(
  parameter int unsigned FRAC  = 14,
  parameter int unsigned K_RCR = 22970,
  parameter int unsigned K_GCB = 5638,
  parameter int unsigned K_GCR = 11700,
  parameter int unsigned K_BCB = 29032
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int unsigned ProdW = 25;
  localparam int unsigned AccW  = 27;

  localparam logic signed [ProdW-1:0] KRcr = ProdW'(K_RCR);
  localparam logic signed [ProdW-1:0] KGcb = ProdW'(K_GCB);
  localparam logic signed [ProdW-1:0] KGcr = ProdW'(K_GCR);
  localparam logic signed [ProdW-1:0] KBcb = ProdW'(K_BCB);
  localparam logic signed [AccW-1:0]  Rnd  = AccW'(1) << (FRAC - 1);
  localparam logic signed [AccW-1:0]  Max8 = AccW'(255);

  // Stage 1: offset-removed chroma
  logic        [7:0]      y_s1;
  logic signed [8:0]      cb_s1, cr_s1;
  // Stage 2: products and scaled luma
  logic signed [AccW-1:0]  yf_s2;
  logic signed [ProdW-1:0] p_rcr_s2, p_gcb_s2, p_gcr_s2, p_bcb_s2;
  // Stage 3: rounded sums
  logic signed [AccW-1:0]  r_s3, g_s3, b_s3;
  // {de, hsync, vsync} taps
  logic [2:0] sync_s1, sync_s2, sync_s3;

  function automatic logic [7:0] sat8(input logic signed [AccW-1:0] acc);
    logic signed [AccW-1:0] q;
    q = acc >>> FRAC;
    if (q[AccW-1]) return 8'h00;
    if (q > Max8)  return 8'hff;
    return q[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      y_s1      <= '0;
      cb_s1     <= '0;
      cr_s1     <= '0;
      yf_s2     <= '0;
      p_rcr_s2  <= '0;
      p_gcb_s2  <= '0;
      p_gcr_s2  <= '0;
      p_bcb_s2  <= '0;
      r_s3      <= '0;
      g_s3      <= '0;
      b_s3      <= '0;
      sync_s1   <= '0;
      sync_s2   <= '0;
      sync_s3   <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (ce) begin
      y_s1     <= Y;
      cb_s1    <= $signed({1'b0, Cb}) - 9'sd128;
      cr_s1    <= $signed({1'b0, Cr}) - 9'sd128;
      sync_s1  <= {de_in, hsync_in, vsync_in};

      yf_s2    <= AccW'(y_s1) << FRAC;
      p_rcr_s2 <= KRcr * ProdW'(cr_s1);
      p_gcb_s2 <= KGcb * ProdW'(cb_s1);
      p_gcr_s2 <= KGcr * ProdW'(cr_s1);
      p_bcb_s2 <= KBcb * ProdW'(cb_s1);
      sync_s2  <= sync_s1;

      r_s3     <= yf_s2 + AccW'(p_rcr_s2) + Rnd;
      g_s3     <= yf_s2 - AccW'(p_gcb_s2) - AccW'(p_gcr_s2) + Rnd;
      b_s3     <= yf_s2 + AccW'(p_bcb_s2) + Rnd;
      sync_s3  <= sync_s2;

      red      <= sat8(r_s3);
      green    <= sat8(g_s3);
      blue     <= sat8(b_s3);
      {de_out, hsync_out, vsync_out} <= sync_s3;
    end
  end

endmodule
